// File: rtl/seg_scan_mux.sv
// Time-multiplexed BCD digit scanner feeding a 7-segment decoder; frame-synchronous commit of new values.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]             divCnt_q, divCnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   active_q, active_d;
  logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
  logic                      pendFlag_q, pendFlag_d;
  logic [3:0]                bcdOut_q, bcdOut_d;
  logic [NUM_DIGITS-1:0]     digitSel_q, digitSel_d;
  logic                      blank_q, blank_d;
  logic                      frameStart_q;
  logic                      lastTick, wrapEdge;
`ifdef SEG_SCAN_LZB_EN
  logic                      upperZero;
`endif

  // Scan/commit next state; outputs are derived from the post-edge index and value so
  // digit 0 on a wrap edge already shows the freshly committed frame.
  always_comb begin
    divCnt_d   = divCnt_q + 1'b1;
    idx_d      = idx_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pendFlag_d = pendFlag_q;
    lastTick   = (divCnt_q == CW'(REFRESH_DIV - 1));
    wrapEdge   = lastTick && (idx_q == IW'(NUM_DIGITS - 1));

    if (lastTick) begin
      divCnt_d = '0;
      idx_d    = wrapEdge ? '0 : idx_q + 1'b1;
    end

    if (wrapEdge) begin
      if (load) begin
        active_d   = digits_in;
        pendFlag_d = 1'b0;
      end else if (pendFlag_q) begin
        active_d   = pending_q;
        pendFlag_d = 1'b0;
      end
    end else if (load) begin
      pending_d  = digits_in;
      pendFlag_d = 1'b1;
    end
  end

  always_comb begin
    bcdOut_d   = '0;
    digitSel_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        bcdOut_d      = active_d[4*k +: 4];
        digitSel_d[k] = 1'b1;
      end
    end
    blank_d = (bcdOut_d > 4'd9);
`ifdef SEG_SCAN_LZB_EN
    // Digits at or above the current position all zero means this one is a leading zero.
    upperZero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_d)) && (active_d[4*k +: 4] != 4'd0)) upperZero = 1'b0;
    end
    if ((idx_d != '0) && upperZero) blank_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q     <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pendFlag_q   <= 1'b0;
      bcdOut_q     <= '0;
      digitSel_q   <= NUM_DIGITS'(1);
      blank_q      <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pendFlag_q   <= pendFlag_d;
      bcdOut_q     <= bcdOut_d;
      digitSel_q   <= digitSel_d;
      blank_q      <= blank_d;
      frameStart_q <= wrapEdge;
    end
  end

  assign bcd_out     = bcdOut_q;
  assign digit_sel   = digitSel_q;
  assign blank       = blank_q;
  assign frame_start = frameStart_q;
  assign busy        = pendFlag_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus random loads/resets,
// compared every cycle against a cycle-count based reference model.
module tb_seg_scan_mux;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel;
  logic          blank;
  logic          frame_start;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Model state: edges since reset, the value on display, and the buffered value.
  int          mEdges = 0;
  logic [15:0] mShown = '0;
  logic [15:0] mPend  = '0;
  bit          mPendV = 1'b0;

  seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .blank(blank),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic modelEdge(input bit r, input bit l, input logic [15:0] d);
    if (r) begin
      mEdges = 0; mShown = '0; mPend = '0; mPendV = 1'b0;
    end else begin
      mEdges++;
      if (mEdges % FRAME == 0) begin
        if (l) begin
          mShown = d; mPendV = 1'b0;
        end else if (mPendV) begin
          mShown = mPend; mPendV = 1'b0;
        end
      end else if (l) begin
        mPend = d; mPendV = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    int          idx;
    logic [15:0] upper;
    logic [3:0]  expBcd;
    logic [ND-1:0] expSel;
    logic        expBlank, expFs;
    idx    = (mEdges / RD) % ND;
    upper  = mShown >> (4 * idx);
    expBcd = upper[3:0];
    expSel = ND'(1) << idx;
    expBlank = (expBcd > 4'd9);
`ifdef SEG_SCAN_LZB_EN
    if (idx != 0 && upper == 16'h0) expBlank = 1'b1;
`endif
    expFs = (mEdges != 0) && (mEdges % FRAME == 0);

    checks++;
    assert (digit_sel === expSel) else begin
      errors++; $error("[TB] FAIL digit_sel edge=%0d observed=%b expected=%b", mEdges, digit_sel, expSel);
    end
    checks++;
    assert (bcd_out === expBcd) else begin
      errors++; $error("[TB] FAIL bcd_out edge=%0d observed=%h expected=%h", mEdges, bcd_out, expBcd);
    end
    checks++;
    assert (blank === expBlank) else begin
      errors++; $error("[TB] FAIL blank edge=%0d observed=%b expected=%b", mEdges, blank, expBlank);
    end
    checks++;
    assert (frame_start === expFs) else begin
      errors++; $error("[TB] FAIL frame_start edge=%0d observed=%b expected=%b", mEdges, frame_start, expFs);
    end
    checks++;
    assert (busy === mPendV) else begin
      errors++; $error("[TB] FAIL busy edge=%0d observed=%b expected=%b", mEdges, busy, mPendV);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit l, input logic [15:0] d);
    rst = r; load = l; digits_in = d;
    @(posedge clk);
    modelEdge(r, l, d);
    #1;
    checkOutput();
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic runToPhase(input int phase);
    for (int i = 0; i < FRAME && (mEdges % FRAME) != phase; i++) applyStimulus(0, 0, '0);
  endtask

  initial begin
    logic [15:0] rnd;

    // Reset and free-run
    applyStimulus(1, 0, '0);
    applyStimulus(1, 1, 16'hFFFF);
    checks++;
    assert (digit_sel === 4'b0001 && bcd_out === 4'h0 && busy === 1'b0) else begin
      errors++; $error("[TB] FAIL reset_state observed=%b/%h/%b expected=0001/0/0", digit_sel, bcd_out, busy);
    end
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, '0);

    // Mid-frame load during idx=1, committed at next wrap
    runToPhase(5);
    applyStimulus(0, 1, 16'h1234);
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(0, 0, '0);

    // Load on the wrap edge while another value is pending
    runToPhase(6);
    applyStimulus(0, 1, 16'h1234);
    runToPhase(15);
    applyStimulus(0, 1, 16'h5678);
    checks++;
    assert (bcd_out === 4'h8 && busy === 1'b0 && frame_start === 1'b1) else begin
      errors++; $error("[TB] FAIL wrap_load observed=%h/%b/%b expected=8/0/1", bcd_out, busy, frame_start);
    end
    for (int i = 0; i < FRAME; i++) applyStimulus(0, 0, '0);

    // Two loads in one frame, last wins
    runToPhase(2);
    applyStimulus(0, 1, 16'h1111);
    runToPhase(9);
    applyStimulus(0, 1, 16'h9999);
    for (int i = 0; i < FRAME + 4; i++) applyStimulus(0, 0, '0);

    // Invalid BCD nibble and leading zeros
    runToPhase(3);
    applyStimulus(0, 1, 16'h00A7);
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(0, 0, '0);

    // Reset mid-frame with a pending value; load during reset is ignored
    runToPhase(7);
    applyStimulus(0, 1, 16'h4321);
    applyStimulus(1, 1, 16'h8888);
    checks++;
    assert (digit_sel === 4'b0001 && bcd_out === 4'h0 && busy === 1'b0) else begin
      errors++; $error("[TB] FAIL rst_mid observed=%b/%h/%b expected=0001/0/0", digit_sel, bcd_out, busy);
    end
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(0, 0, '0);

    // Random loads, values with frequent leading zeros, occasional reset
    for (int i = 0; i < 400; i++) begin
      rnd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rnd[15:8] = 8'h00;
      if ($urandom_range(0, 2) == 0) rnd[7:4] = 4'h0;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rnd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed digit scanner sitting directly upstream of the 7-segment decoder.
- Holds NUM_DIGITS BCD digits and presents one digit at a time on bcd_out. The decoder turns bcd_out into segments a..g.
- Drives a one-hot digit_sel to the common pins of the display.
- Updates to the displayed value are buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range 2..8.
- REFRESH_DIV, 1000, clock cycles each digit stays selected; legal minimum 2.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- load, input, 1, one-cycle strobe that captures digits_in.
- digits_in, input, 4*NUM_DIGITS, BCD digits; bits [3:0] = digit 0 (least significant, rightmost).
- bcd_out, output, 4, nibble of the selected digit, fed to the decoder input i.
- digit_sel, output, NUM_DIGITS, one-hot digit enable, active-high; bit k selects digit k.
- blank, output, 1, 1 = decoder output must be suppressed for the current digit.
- frame_start, output, 1, one-cycle pulse on the edge where the scan wraps to digit 0.
- busy, output, 1, 1 while a captured value is waiting for commit.

Behaviour:
- Single clock domain; reset is synchronous, active-high. All outputs are registered.
- Reset values:
  - div_cnt=0, idx=0, active=0, pending=0, pend_flag=0.
  - digit_sel = one-hot bit 0; bcd_out=0; blank=0; frame_start=0; busy=0.
- Refresh counter:
  - div_cnt counts 0..REFRESH_DIV-1.
  - On the edge where div_cnt==REFRESH_DIV-1: div_cnt<=0 and idx advances.
  - Otherwise div_cnt increments.
- Scan index:
  - idx = idx+1, wrapping NUM_DIGITS-1 -> 0.
  - digit_sel, bcd_out and blank update on the same edge as idx, so each digit is held exactly REFRESH_DIV cycles.
  - Frame = NUM_DIGITS*REFRESH_DIV cycles.
- Wrap edge (idx NUM_DIGITS-1 -> 0):
  - frame_start=1 for that one cycle.
  - Commit priority:
    - If load=1 on that edge: active<=digits_in and pend_flag<=0.
    - Else if pend_flag=1: active<=pending and pend_flag<=0.
  - The digit-0 outputs presented on that edge already use the newly committed value.
- Load on a non-wrap edge:
  - pending<=digits_in and pend_flag<=1.
  - A later load before commit overwrites pending; the last value wins.
- busy = pend_flag, registered.
- bcd_out = active[4*idx+3 : 4*idx] for the idx being presented.
- blank = 1 when that nibble > 9 (invalid BCD). bcd_out still carries the raw nibble.
- rst asserted mid-frame or with a pending load: all state returns to reset values and the pending value is discarded.
- load during rst is ignored.
- digit_sel is always exactly one-hot, never all-zero after reset.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- When defined:
  - For idx != 0, blank also = 1 if every digit of active at positions idx..NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked by this rule, so 0000 shows as a single "0".
  - Blanking is evaluated on the committed active value only.
- When undefined: blank depends solely on the invalid-BCD check; all digits always display.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset, then free-run 32 cycles:
  - digit_sel sequence 0001,0010,0100,1000, each held 4 cycles.
  - bcd_out=0, blank=0.
  - frame_start pulses every 16 cycles.
- load=1 with digits_in=16'h1234 mid-frame (during idx=1):
  - busy=1 until the next wrap; displayed digits stay 0 until then.
  - After the wrap: bcd_out sequence 4,3,2,1; busy=0.
- load with 16'h5678 on the exact wrap edge while 16'h1234 is pending:
  - 5678 is committed directly; digit 0 shows 8 on that edge; 1234 is never shown; busy=0.
- Two loads (16'h1111, then 16'h9999) within one frame:
  - Only 9999 is committed at the next wrap.
- active=16'h00A7:
  - digit 1 (A) shows blank=1, bcd_out=4'hA.
  - With SEG_SCAN_LZB_EN: digits 2,3 blank=1, digit 0 blank=0.
  - Without it: digits 2,3 blank=0.
- rst pulse mid-frame with busy=1:
  - Next cycle digit_sel=0001, bcd_out=0, busy=0.
  - The pending value is never displayed.
